// File: rtl/player2_ctrl.sv
// Player 2 movement controller: synchronizes three buttons and, once per video frame,
// moves the blob horizontally inside the right half-court and runs a simple jump/gravity model.
module player2_ctrl #(
  parameter int unsigned X_START  = 800,
  parameter int unsigned X_MIN    = 544,
  parameter int unsigned X_MAX    = 920,
  parameter int unsigned Y_GROUND = 624,
  parameter int unsigned Y_MIN    = 300,
  parameter int unsigned STEP_X   = 4,
  parameter int unsigned JUMP_V0  = 16,
  parameter int unsigned GRAVITY  = 1
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        in_air,
  output logic        frame_tick
);

  localparam int unsigned PW = 12;
  localparam int unsigned AW = 13;
  localparam int unsigned VW = 8;

  localparam logic [0:0] GROUND = 1'b0;
  localparam logic [0:0] AIR    = 1'b1;

  localparam logic signed [AW-1:0] Y_GND_S = AW'(Y_GROUND);
  localparam logic signed [AW-1:0] Y_MIN_S = AW'(Y_MIN);
  localparam logic signed [AW-1:0] X_MIN_S = AW'(X_MIN);
  localparam logic signed [AW-1:0] X_MAX_S = AW'(X_MAX);
  localparam logic signed [AW-1:0] STEP_S  = AW'(STEP_X);
  localparam logic signed [VW-1:0] V0_S    = VW'(JUMP_V0);
  localparam logic signed [VW-1:0] GRAV_S  = VW'(GRAVITY);

  // Button bit order: {jump, right, left}
  logic [2:0] sync1_q, sync2_q;
  logic       vs_q, tick_q;

  logic [PW-1:0]        x_q, x_d, y_q, y_d;
  logic signed [VW-1:0] vel_q, vel_d;
  logic [0:0]           state_q, state_d;

  logic signed [AW-1:0] x_sub, x_add, y_n;

  // Synchronizers, vsync edge detect and movement state
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      vs_q    <= 1'b0;
      tick_q  <= 1'b0;
      x_q     <= PW'(X_START);
      y_q     <= PW'(Y_GROUND);
      vel_q   <= '0;
      state_q <= GROUND;
    end else begin
      sync1_q <= {btn_jump, btn_right, btn_left};
      sync2_q <= sync1_q;
      vs_q    <= vsync_in;
      tick_q  <= vsync_in & ~vs_q;
      x_q     <= x_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      state_q <= state_d;
    end
  end

  // Per-frame position update; 13-bit signed math keeps the clamps wrap-free
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    vel_d   = vel_q;
    state_d = state_q;
    x_sub   = $signed({1'b0, x_q}) - STEP_S;
    x_add   = $signed({1'b0, x_q}) + STEP_S;
    y_n     = $signed({1'b0, y_q}) + AW'(vel_q);

    if (tick_q) begin
      case (sync2_q[1:0])
        2'b01:   x_d = (x_sub < X_MIN_S) ? PW'(X_MIN) : x_sub[PW-1:0];
        2'b10:   x_d = (x_add > X_MAX_S) ? PW'(X_MAX) : x_add[PW-1:0];
        default: x_d = x_q;
      endcase

      case (state_q)
        GROUND: begin
          if (sync2_q[2]) begin
            vel_d   = -V0_S;
            y_d     = PW'(Y_GROUND - JUMP_V0);
            state_d = AIR;
          end
        end
        AIR: begin
          if (y_n >= Y_GND_S) begin
            y_d     = PW'(Y_GROUND);
            vel_d   = '0;
            state_d = GROUND;
          end else if (y_n < Y_MIN_S) begin
            y_d   = PW'(Y_MIN);
            vel_d = '0;
          end else begin
            y_d   = y_n[PW-1:0];
            vel_d = vel_q + GRAV_S;
          end
        end
        default: state_d = GROUND;
      endcase
    end
  end

  assign xpos       = x_q;
  assign ypos       = y_q;
  assign in_air     = (state_q == AIR);
  assign frame_tick = tick_q;

endmodule
